unified_mem_arbiter: RTL and testbench

Sequential arbiter and access sequencer that shares one single-ported unified memory between the instruction-fetch port and the data (load/store) port of the rv32i pipeline. It grants one requester at a time, drives the memory for a fixed read latency, registers the returned word and pulses a per-port ready. The pipeline control logic uses its stall outputs to freeze the pipeline registers while an access is outstanding.

---
 rtl/unified_mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
//   Shares one single-ported unified memory between the rv32i fetch port and
//   the load/store port. One access at a time: IDLE -> ISSUE (one mem_en
//   cycle) -> WAIT (MEM_LAT cycles) -> RESP (one-cycle ready pulse).
//
//   Parameters: MEM_LAT (1..4) read latency from mem_en to valid mem_rdata,
//               ADDR_W byte-address width.
//   Ports:
//     clk_i, rst_i                  clock, synchronous active-high reset
//     if_req_i/if_addr_i            fetch request (held until if_ready_o)
//     if_rdata_o/if_ready_o         registered fetch word, one-cycle ready
//     if_stall_o                    if_req_i & ~if_ready_o
//     d_req_i/d_we_i/d_addr_i/
//     d_wdata_i/d_wstrb_i           load/store request (held until d_ready_o)
//     d_rdata_o/d_ready_o           registered load word, one-cycle ready
//     d_stall_o                     d_req_i & ~d_ready_o
//     mem_en_o/mem_we_o/mem_addr_o/
//     mem_wdata_o/mem_wstrb_o       memory strobe and write side (0 outside ISSUE)
//     mem_rdata_i                   memory read data
//
//   Build option: ARB_FAIR_EN -- alternate grants when both ports are pending
//   (last_grant register); undefined gives fixed data-over-fetch priority.
module unified_mem_arbiter #(
  parameter int MEM_LAT = 1,
  parameter int ADDR_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [31:0]       if_rdata_o,
  output logic              if_ready_o,
  output logic              if_stall_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [31:0]       d_wdata_i,
  input  logic [3:0]        d_wstrb_i,
  output logic [31:0]       d_rdata_o,
  output logic              d_ready_o,
  output logic              d_stall_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [3:0]        mem_wstrb_o,
  input  logic [31:0]       mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  // Latched access, captured at the IDLE edge so requesters may change
  // their inputs while the access is in flight.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
  } acc_t;

  localparam logic [2:0] LAT = 3'(MEM_LAT);

  state_t      state_q, state_d;
  logic        grant_q, grant_d;   // 0 = fetch, 1 = data
  logic [2:0]  cnt_q, cnt_d;
  acc_t        acc_q, acc_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        pick;               // port that would win in IDLE

`ifdef ARB_FAIR_EN
  logic last_grant_q, last_grant_d;

  // Contended: hand the grant to whoever lost last time.
  assign pick = (if_req_i && d_req_i) ? ~last_grant_q : d_req_i;

  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == IDLE && (if_req_i || d_req_i)) last_grant_d = pick;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) last_grant_q <= 1'b0;
    else       last_grant_q <= last_grant_d;
  end
`else
  assign pick = d_req_i;
`endif

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wstrb_o = '0;
    if_ready_o  = 1'b0;
    d_ready_o   = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_req_i || d_req_i) begin
          grant_d = pick;
          if (pick) begin
            acc_d.we    = d_we_i;
            acc_d.addr  = d_addr_i;
            acc_d.wdata = d_wdata_i;
            acc_d.wstrb = d_wstrb_i;
          end else begin
            acc_d.we    = 1'b0;
            acc_d.addr  = if_addr_i;
            acc_d.wdata = '0;
            acc_d.wstrb = '0;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        mem_en_o    = 1'b1;
        mem_we_o    = acc_q.we;
        mem_addr_o  = {acc_q.addr[ADDR_W-1:2], 2'b00};
        mem_wdata_o = acc_q.wdata;
        mem_wstrb_o = acc_q.wstrb;
        cnt_d       = 3'd1;
        state_d     = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 3'd1;
        // Stores sit here for the same count so every access has equal length.
        if (cnt_q == LAT) begin
          if (!acc_q.we) begin
            if (grant_q) d_rdata_d  = mem_rdata_i;
            else         if_rdata_d = mem_rdata_i;
          end
          state_d = RESP;
        end
      end
      RESP: begin
        if_ready_o = ~grant_q;
        d_ready_o  = grant_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      grant_q    <= 1'b0;
      cnt_q      <= '0;
      acc_q      <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign if_rdata_o = if_rdata_q;
  assign d_rdata_o  = d_rdata_q;
  assign if_stall_o = if_req_i & ~if_ready_o;
  assign d_stall_o  = d_req_i & ~d_ready_o;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench: instance A (MEM_LAT=1) for the main sequences, instance B
// (MEM_LAT=3) for the mid-access reset. Inputs are shared, resets are not.
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [3:0]  d_wstrb;

  logic [31:0] if_rdata_a, d_rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
  logic        if_ready_a, if_stall_a, d_ready_a, d_stall_a, mem_en_a, mem_we_a;
  logic [3:0]  mem_wstrb_a;
  logic [31:0] if_rdata_b, d_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;
  logic        if_ready_b, if_stall_b, d_ready_b, d_stall_b, mem_en_b, mem_we_b;
  logic [3:0]  mem_wstrb_b;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  unified_mem_arbiter #(.MEM_LAT(1), .ADDR_W(32)) dut_a (
    .clk_i(clk), .rst_i(rst_a),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata_a),
    .if_ready_o(if_ready_a), .if_stall_o(if_stall_a),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_wstrb_i(d_wstrb), .d_rdata_o(d_rdata_a), .d_ready_o(d_ready_a),
    .d_stall_o(d_stall_a), .mem_en_o(mem_en_a), .mem_we_o(mem_we_a),
    .mem_addr_o(mem_addr_a), .mem_wdata_o(mem_wdata_a),
    .mem_wstrb_o(mem_wstrb_a), .mem_rdata_i(mem_rdata_a));

  unified_mem_arbiter #(.MEM_LAT(3), .ADDR_W(32)) dut_b (
    .clk_i(clk), .rst_i(rst_b),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata_b),
    .if_ready_o(if_ready_b), .if_stall_o(if_stall_b),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_wstrb_i(d_wstrb), .d_rdata_o(d_rdata_b), .d_ready_o(d_ready_b),
    .d_stall_o(d_stall_b), .mem_en_o(mem_en_b), .mem_we_o(mem_we_b),
    .mem_addr_o(mem_addr_b), .mem_wdata_o(mem_wdata_b),
    .mem_wstrb_o(mem_wstrb_b), .mem_rdata_i(mem_rdata_b));

  // Memory contents: one fixed instruction word, an address pattern elsewhere.
  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h10) return 32'h0050_0093;
    return {~a[15:0], a[15:0]};
  endfunction

  // Read data is valid only exactly MEM_LAT cycles after mem_en; garbage otherwise.
  logic [31:0] pa;
  logic [31:0] pb [0:2];
  always @(posedge clk) begin
    pa    <= mem_en_a ? memf(mem_addr_a) : 32'hBAD0_BAD0;
    pb[0] <= mem_en_b ? memf(mem_addr_b) : 32'hBAD0_BAD0;
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end
  assign mem_rdata_a = pa;
  assign mem_rdata_b = pb[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Cycles until instance A pulses any ready, bounded.
  task automatic wait_rdy_a(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!(if_ready_a || d_ready_a) && n < 12);
  endtask

  initial begin
    int  n;
    logic expd, seen;
    rst_a = 1'b1; rst_b = 1'b1;
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; d_wstrb = '0;
    cyc(2);
    // reset state
    chk("rst mem_en",   {31'b0, mem_en_a},   32'd0);
    chk("rst mem_we",   {31'b0, mem_we_a},   32'd0);
    chk("rst mem_addr", mem_addr_a,          32'd0);
    chk("rst mem_wdata", mem_wdata_a,        32'd0);
    chk("rst mem_wstrb", {28'b0, mem_wstrb_a}, 32'd0);
    chk("rst if_rdata", if_rdata_a,          32'd0);
    chk("rst d_rdata",  d_rdata_a,           32'd0);
    chk("rst readys",   {30'b0, if_ready_a, d_ready_a}, 32'd0);
    rst_a = 1'b0; rst_b = 1'b0;

    // single misaligned fetch
    if_req = 1'b1; if_addr = 32'h13;
    cyc(1);
    chk("f1 mem_en",   {31'b0, mem_en_a}, 32'd1);
    chk("f1 mem_addr", mem_addr_a,        32'h10);
    chk("f1 mem_we",   {31'b0, mem_we_a}, 32'd0);
    chk("f1 if_stall", {31'b0, if_stall_a}, 32'd1);
    cyc(1);
    chk("f2 mem_en",   {31'b0, mem_en_a}, 32'd0);
    chk("f2 mem_addr", mem_addr_a,        32'd0);
    chk("f2 if_ready", {31'b0, if_ready_a}, 32'd0);
    cyc(1);
    chk("f3 if_ready", {31'b0, if_ready_a}, 32'd1);
    chk("f3 if_rdata", if_rdata_a,          32'h0050_0093);
    chk("f3 if_stall", {31'b0, if_stall_a}, 32'd0);
    chk("f3 d_ready",  {31'b0, d_ready_a},  32'd0);
    if_req = 1'b0;
    cyc(1);
    chk("f4 if_ready", {31'b0, if_ready_a}, 32'd0);

    // store
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b0011;
    cyc(1);
    chk("s1 mem_en",    {31'b0, mem_en_a},    32'd1);
    chk("s1 mem_we",    {31'b0, mem_we_a},    32'd1);
    chk("s1 mem_wstrb", {28'b0, mem_wstrb_a}, 32'd3);
    chk("s1 mem_wdata", mem_wdata_a,          32'hDEAD_BEEF);
    chk("s1 mem_addr",  mem_addr_a,           32'h20);
    chk("s1 d_stall",   {31'b0, d_stall_a},   32'd1);
    cyc(1);
    chk("s2 mem_en",    {31'b0, mem_en_a},    32'd0);
    chk("s2 mem_wdata", mem_wdata_a,          32'd0);
    cyc(1);
    chk("s3 d_ready",   {31'b0, d_ready_a},   32'd1);
    chk("s3 d_rdata",   d_rdata_a,            32'd0);
    chk("s3 if_rdata hold", if_rdata_a,       32'h0050_0093);
    chk("s3 d_stall",   {31'b0, d_stall_a},   32'd0);
    // new access presented in the ready cycle: misaligned, zero strobes
    d_addr = 32'h23; d_wstrb = 4'b0000; d_wdata = 32'h1234_5678;
    cyc(2);
    chk("z mem_en",    {31'b0, mem_en_a},    32'd1);
    chk("z mem_addr",  mem_addr_a,           32'h20);
    chk("z mem_we",    {31'b0, mem_we_a},    32'd1);
    chk("z mem_wstrb", {28'b0, mem_wstrb_a}, 32'd0);
    cyc(2);
    chk("z d_ready",   {31'b0, d_ready_a},   32'd1);
    d_req = 1'b0; d_we = 1'b0; d_wstrb = '0; d_wdata = '0;
    cyc(1);

    // contention from a clean reset (last_grant = 0)
    rst_a = 1'b1;
    cyc(1);
    rst_a = 1'b0;
    chk("r2 d_rdata", d_rdata_a, 32'd0);
    if_req = 1'b1; if_addr = 32'h80; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_FAIR_EN
      expd = (k % 2 == 0);
`else
      expd = 1'b1;
`endif
      wait_rdy_a(n);
      chk($sformatf("arb%0d cycles", k), n, (k == 0) ? 32'd3 : 32'd4);
      chk($sformatf("arb%0d d_ready", k), {31'b0, d_ready_a}, {31'b0, expd});
      chk($sformatf("arb%0d if_ready", k), {31'b0, if_ready_a}, {31'b0, ~expd});
      if (expd) chk($sformatf("arb%0d d_rdata", k), d_rdata_a, memf(32'h44));
      else      chk($sformatf("arb%0d if_rdata", k), if_rdata_a, memf(32'h80));
      chk($sformatf("arb%0d if_stall", k), {31'b0, if_stall_a}, {31'b0, expd});
    end
    d_req = 1'b0;
    wait_rdy_a(n);
    chk("arb fetch cycles", n, 32'd4);
    chk("arb fetch ready",  {31'b0, if_ready_a}, 32'd1);
    chk("arb fetch rdata",  if_rdata_a, memf(32'h80));
    if_req = 1'b0;
    cyc(1);

    // fetch request dropped during WAIT
    if_req = 1'b1; if_addr = 32'h30;
    cyc(2);
    if_req = 1'b0;
    cyc(1);
    chk("drop if_ready", {31'b0, if_ready_a}, 32'd1);
    chk("drop if_rdata", if_rdata_a, memf(32'h30));
    cyc(1);
    chk("drop idle1 mem_en", {31'b0, mem_en_a}, 32'd0);
    cyc(1);
    chk("drop idle2 mem_en", {31'b0, mem_en_a}, 32'd0);

    // MEM_LAT=3: reset while in WAIT
    rst_b = 1'b1;
    cyc(1);
    rst_b = 1'b0;
    if_req = 1'b1; if_addr = 32'h100;
    cyc(1);
    chk("b issue mem_en", {31'b0, mem_en_b}, 32'd1);
    cyc(1);
    rst_b = 1'b1;
    cyc(1);
    chk("b rst mem_en",   {31'b0, mem_en_b},   32'd0);
    chk("b rst if_ready", {31'b0, if_ready_b}, 32'd0);
    chk("b rst mem_addr", mem_addr_b,          32'd0);
    chk("b rst if_rdata", if_rdata_b,          32'd0);
    rst_b = 1'b0; if_req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      seen |= if_ready_b | mem_en_b;
    end
    chk("b no ready after abort", {31'b0, seen}, 32'd0);
    if_req = 1'b1; if_addr = 32'h104;
    n = 0;
    do begin @(negedge clk); n++; end while (!if_ready_b && n < 12);
    chk("b fetch cycles", n, 32'd5);
    chk("b fetch rdata",  if_rdata_b, memf(32'h104));
    if_req = 1'b0;
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
